// File: rtl/fetch_unit_param.sv
// fetch_unit_param
// Instruction fetch stage: holds the PC, selects the next PC, fetches one or
// two halfwords from a dual-read instruction memory, decodes the instruction
// length and registers the result into the IF/ID pipeline stage. It also
// contains the interrupt-entry FSM, which captures the EPC and redirects the
// PC to INT_VECTOR.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   stall_i, flush_i    hold PC and IF/ID / turn IF/ID into a bubble
//   jump_i/_target_i    decode-stage jump redirect
//   branch_i/_target_i  execute-stage taken branch
//   ret_i/_target_i     memory-stage RET/RTI redirect
//   irq_i               level-sensitive interrupt request
//   imem_addr_o         fetch address (the PC)
//   imem_rdata0_i/1_i   halfwords at PC and PC+1
//   ifid_*              registered IF/ID stage contents
//   irq_ack_o           one-cycle pulse after interrupt entry
//   epc_o               return PC captured at interrupt entry
module fetch_unit_param #(
  parameter int IW = 16,
  parameter int AW = 32,
  parameter logic [AW-1:0] RESET_VECTOR = 32,
  parameter logic [AW-1:0] INT_VECTOR = 0,
  parameter int LONG_BIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            jump_i,
  input  logic [AW-1:0]   jump_target_i,
  input  logic            branch_i,
  input  logic [AW-1:0]   branch_target_i,
  input  logic            ret_i,
  input  logic [AW-1:0]   ret_target_i,
  input  logic            irq_i,
  output logic [AW-1:0]   imem_addr_o,
  input  logic [IW-1:0]   imem_rdata0_i,
  input  logic [IW-1:0]   imem_rdata1_i,
  output logic            ifid_valid_o,
  output logic [2*IW-1:0] ifid_instr_o,
  output logic            ifid_long_o,
  output logic [AW-1:0]   ifid_pc_o,
  output logic [AW-1:0]   ifid_next_pc_o,
  output logic            irq_ack_o,
  output logic [AW-1:0]   epc_o
);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    WAIT_RELEASE
  } irq_state_t;

  irq_state_t      state;
  logic [AW-1:0]   pc;
  logic            redirect;
  logic            entry;
  logic            is_long;
  logic [2*IW-1:0] instr;
  logic [AW-1:0]   seq_pc;
  logic [AW-1:0]   next_pc;

  assign imem_addr_o = pc;

  // Length decode, sequential successor and next-PC priority selection.
  // Interrupt entry is only taken on a cycle free of redirects and stalls,
  // so a deferred interrupt later captures the redirected PC as its EPC.
  always_comb begin
    redirect = ret_i | branch_i | jump_i;
    entry    = (state == PENDING) && !redirect && !stall_i;
    is_long  = imem_rdata0_i[LONG_BIT];
    instr    = is_long ? {imem_rdata0_i, imem_rdata1_i} : {imem_rdata0_i, {IW{1'b0}}};
    seq_pc   = pc + (is_long ? AW'(2) : AW'(1));
    if (ret_i)
      next_pc = ret_target_i;
    else if (branch_i)
      next_pc = branch_target_i;
    else if (jump_i)
      next_pc = jump_target_i;
    else if (entry)
      next_pc = INT_VECTOR;
    else if (stall_i)
      next_pc = pc;
    else
      next_pc = seq_pc;
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pc <= RESET_VECTOR;
    else
      pc <= next_pc;
  end

  // IF/ID stage: flush, redirect and interrupt entry all insert a bubble and
  // take precedence over stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_valid_o   <= 1'b0;
      ifid_instr_o   <= '0;
      ifid_long_o    <= 1'b0;
      ifid_pc_o      <= '0;
      ifid_next_pc_o <= '0;
    end else if (flush_i || redirect || entry) begin
      ifid_valid_o   <= 1'b0;
      ifid_instr_o   <= '0;
      ifid_long_o    <= 1'b0;
      ifid_pc_o      <= '0;
      ifid_next_pc_o <= '0;
    end else if (!stall_i) begin
      ifid_valid_o   <= 1'b1;
      ifid_instr_o   <= instr;
      ifid_long_o    <= is_long;
      ifid_pc_o      <= pc;
      ifid_next_pc_o <= seq_pc;
    end
  end

  // Interrupt-entry FSM. The request is latched into PENDING, and after entry
  // the FSM waits for irq_i to drop so a held level produces a single entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      irq_ack_o <= 1'b0;
      epc_o     <= '0;
    end else begin
      irq_ack_o <= entry;
      case (state)
        IDLE: begin
          if (irq_i)
            state <= PENDING;
        end
        PENDING: begin
          if (entry) begin
            epc_o <= pc;
            state <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (!irq_i)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit_param.sv
// tb_fetch_unit_param
// Directed self-checking bench for fetch_unit_param. A small instruction
// memory model answers both read ports; expected values are hand-computed.
module tb_fetch_unit_param;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        flush_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        ret_i;
  logic [31:0] ret_target_i;
  logic        irq_i;
  logic [31:0] imem_addr_o;
  logic [15:0] imem_rdata0_i;
  logic [15:0] imem_rdata1_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_long_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_next_pc_o;
  logic        irq_ack_o;
  logic [31:0] epc_o;

  logic [15:0] wrap_word;
  int          vectors;
  int          misses;

  fetch_unit_param #(
    .IW(16), .AW(32), .RESET_VECTOR(32'd32), .INT_VECTOR(32'd0), .LONG_BIT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall_i(stall_i),
    .flush_i(flush_i),
    .jump_i(jump_i),
    .jump_target_i(jump_target_i),
    .branch_i(branch_i),
    .branch_target_i(branch_target_i),
    .ret_i(ret_i),
    .ret_target_i(ret_target_i),
    .irq_i(irq_i),
    .imem_addr_o(imem_addr_o),
    .imem_rdata0_i(imem_rdata0_i),
    .imem_rdata1_i(imem_rdata1_i),
    .ifid_valid_o(ifid_valid_o),
    .ifid_instr_o(ifid_instr_o),
    .ifid_long_o(ifid_long_o),
    .ifid_pc_o(ifid_pc_o),
    .ifid_next_pc_o(ifid_next_pc_o),
    .irq_ack_o(irq_ack_o),
    .epc_o(epc_o)
  );

  // Memory contents: a few fixed words, the top address is programmable, and
  // everything else is a short instruction equal to its own low address bits.
  function automatic logic [15:0] mem_read(input logic [31:0] a, input logic [15:0] ww);
    case (a)
      32'd32:        return 16'h1234;
      32'd33:        return 16'h8001;
      32'd34:        return 16'hABCD;
      32'hFFFF_FFFF: return ww;
      default:       return {1'b0, a[14:0]};
    endcase
  endfunction

  assign imem_rdata0_i = mem_read(imem_addr_o, wrap_word);
  assign imem_rdata1_i = mem_read(imem_addr_o + 32'd1, wrap_word);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of control inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic st, input logic fl,
                               input logic jp, input logic [31:0] jt,
                               input logic br, input logic [31:0] bt,
                               input logic rt, input logic [31:0] rtt,
                               input logic irq);
    stall_i = st;         flush_i = fl;
    jump_i = jp;          jump_target_i = jt;
    branch_i = br;        branch_target_i = bt;
    ret_i = rt;           ret_target_i = rtt;
    irq_i = irq;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    misses = 0;
    wrap_word = 16'h7FFF;
    reset = 1'b0;
    stall_i = 0; flush_i = 0; jump_i = 0; branch_i = 0; ret_i = 0; irq_i = 0;
    jump_target_i = 0; branch_target_i = 0; ret_target_i = 0;
    #6;
    checkOutput("reset_pc", 64'(imem_addr_o), 64'd32);
    checkOutput("reset_valid", 64'(ifid_valid_o), 64'd0);
    checkOutput("reset_ack", 64'(irq_ack_o), 64'd0);
    checkOutput("reset_epc", 64'(epc_o), 64'd0);
    #1 reset = 1'b1;

    // Reset release: short at 32, then long at 33
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rel_pc0", 64'(ifid_pc_o), 64'd32);
    checkOutput("rel_instr0", 64'(ifid_instr_o), 64'h1234_0000);
    checkOutput("rel_long0", 64'(ifid_long_o), 64'd0);
    checkOutput("rel_valid0", 64'(ifid_valid_o), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rel_pc1", 64'(ifid_pc_o), 64'd33);
    checkOutput("rel_instr1", 64'(ifid_instr_o), 64'h8001_ABCD);
    checkOutput("rel_long1", 64'(ifid_long_o), 64'd1);
    checkOutput("rel_next1", 64'(ifid_next_pc_o), 64'd35);
    checkOutput("rel_addr", 64'(imem_addr_o), 64'd35);

    // Stall at PC=40 with instruction 39 held in IF/ID
    applyStimulus(0, 0, 1, 32'd39, 0, 0, 0, 0, 0);
    checkOutput("jmp_bubble", 64'(ifid_valid_o), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pre_stall_addr", 64'(imem_addr_o), 64'd40);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("stall_addr", 64'(imem_addr_o), 64'd40);
      checkOutput("stall_ifid_pc", 64'(ifid_pc_o), 64'd39);
      checkOutput("stall_instr", 64'(ifid_instr_o), 64'h0027_0000);
    end
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_valid", 64'(ifid_valid_o), 64'd0);
    checkOutput("flush_addr", 64'(imem_addr_o), 64'd40);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("unstall_pc", 64'(ifid_pc_o), 64'd40);
    checkOutput("unstall_next", 64'(ifid_next_pc_o), 64'd41);

    // Simultaneous redirects
    applyStimulus(0, 0, 1, 32'h300, 1, 32'h200, 1, 32'h100, 0);
    checkOutput("redir3_addr", 64'(imem_addr_o), 64'h100);
    checkOutput("redir3_valid", 64'(ifid_valid_o), 64'd0);
    applyStimulus(1, 0, 1, 32'h300, 1, 32'h200, 0, 0, 0);
    checkOutput("redir2_addr", 64'(imem_addr_o), 64'h200);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("redir_target", 64'(ifid_pc_o), 64'h200);
    checkOutput("redir_valid", 64'(ifid_valid_o), 64'd1);

    // Interrupt at PC=50
    applyStimulus(0, 0, 1, 32'd50, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("irq_pend_ack", 64'(irq_ack_o), 64'd0);
    checkOutput("irq_pend_pc", 64'(ifid_pc_o), 64'd50);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("irq_ack", 64'(irq_ack_o), 64'd1);
    checkOutput("irq_epc", 64'(epc_o), 64'd51);
    checkOutput("irq_vec", 64'(imem_addr_o), 64'd0);
    checkOutput("irq_bubble", 64'(ifid_valid_o), 64'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("irq_held_ack", 64'(irq_ack_o), 64'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("irq2_pend_addr", 64'(imem_addr_o), 64'd12);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("irq2_ack", 64'(irq_ack_o), 64'd1);
    checkOutput("irq2_epc", 64'(epc_o), 64'd12);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("irq2_ack_drop", 64'(irq_ack_o), 64'd0);

    // Interrupt deferred by stall and branch
    applyStimulus(0, 0, 1, 32'h60, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("defer_stall_ack", 64'(irq_ack_o), 64'd0);
      checkOutput("defer_stall_addr", 64'(imem_addr_o), 64'h61);
    end
    applyStimulus(0, 0, 0, 0, 1, 32'h80, 0, 0, 0);
    checkOutput("defer_br_ack", 64'(irq_ack_o), 64'd0);
    checkOutput("defer_br_addr", 64'(imem_addr_o), 64'h80);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("defer_ack", 64'(irq_ack_o), 64'd1);
    checkOutput("defer_epc", 64'(epc_o), 64'h80);
    checkOutput("defer_vec", 64'(imem_addr_o), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("defer_ack_drop", 64'(irq_ack_o), 64'd0);

    // Address wrap at the top of memory, short then long
    applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_short_next", 64'(ifid_next_pc_o), 64'd0);
    checkOutput("wrap_short_instr", 64'(ifid_instr_o), 64'h7FFF_0000);
    checkOutput("wrap_short_addr", 64'(imem_addr_o), 64'd0);
    wrap_word = 16'h8000;
    applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_long_next", 64'(ifid_next_pc_o), 64'd1);
    checkOutput("wrap_long_flag", 64'(ifid_long_o), 64'd1);
    checkOutput("wrap_long_addr", 64'(imem_addr_o), 64'd1);

    // Asynchronous reset in the middle of a cycle
    #2 reset = 1'b0;
    #1;
    checkOutput("areset_addr", 64'(imem_addr_o), 64'd32);
    checkOutput("areset_valid", 64'(ifid_valid_o), 64'd0);
    checkOutput("areset_ifid_pc", 64'(ifid_pc_o), 64'd0);
    checkOutput("areset_epc", 64'(epc_o), 64'd0);
    #10 reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/fetch_unit_param.md
Name: fetch_unit_param

Overview:
Parametrised successor to the current fetch path (PC mux, two half-fetches and the IF/ID buffer), merged into one block.
- Holds the PC and selects the next PC (reset, return, branch, jump, interrupt, stall, sequential).
- Fetches one or two instruction halfwords from a dual-read instruction memory.
- Adds variable-length decode (16/32-bit), a latched interrupt-entry FSM with EPC capture, and a registered IF/ID stage with valid bit.
- Sits between instruction memory and Decode.

Parameters:
IW, 16, instruction halfword width (bits)
AW, 32, PC / address width; memory is halfword-addressed
RESET_VECTOR, 32, PC value after reset
INT_VECTOR, 0, PC loaded on interrupt entry
LONG_BIT, 15, bit of first halfword that marks a 32-bit instruction (1 = long)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall_i  in  1  hazard stall: hold PC and IF/ID
flush_i  in  1  clear IF/ID to a bubble
jump_i  in  1  jump redirect, resolved in decode
jump_target_i  in  AW  jump target
branch_i  in  1  taken branch, resolved in execute
branch_target_i  in  AW  branch target
ret_i  in  1  RET/RTI redirect, resolved in memory
ret_target_i  in  AW  popped PC
irq_i  in  1  level interrupt request
imem_addr_o  out  AW  fetch address (= PC)
imem_rdata0_i  in  IW  memory word at imem_addr_o (combinational)
imem_rdata1_i  in  IW  memory word at imem_addr_o+1 (combinational)
ifid_valid_o  out  1  IF/ID holds a real instruction
ifid_instr_o  out  2*IW  {first halfword, second halfword or 0}
ifid_long_o  out  1  instruction is 32-bit
ifid_pc_o  out  AW  PC of the instruction
ifid_next_pc_o  out  AW  sequential successor PC
irq_ack_o  out  1  one-cycle pulse on interrupt entry
epc_o  out  AW  return PC captured at interrupt entry

Behaviour:
- Reset (reset=0, async):
  - PC=RESET_VECTOR; all IF/ID outputs 0 (valid=0).
  - irq_ack_o=0, epc_o=0, FSM=IDLE.
  - Asserting reset mid-operation discards pending interrupts and redirects.
- imem_addr_o = PC, combinational from the PC register.
- Length decode:
  - long = imem_rdata0_i[LONG_BIT].
  - instr = long ? {rdata0, rdata1} : {rdata0, IW'0}.
  - seq = PC + (long ? 2 : 1), modulo 2^AW (wraps at max address).
- Next-PC priority, evaluated each rising edge:
  1. ret_i → ret_target_i
  2. branch_i → branch_target_i
  3. jump_i → jump_target_i
  4. interrupt entry → INT_VECTOR
  5. stall_i → hold
  6. otherwise → seq
- Redirects (priorities 1-3) and interrupt entry override stall_i.
- IF/ID register on each edge:
  - Load a bubble (valid=0, instr=0, long=0; pc/next_pc=0) if flush_i, any redirect, or interrupt entry.
  - Otherwise, if stall_i: hold.
  - Otherwise: load valid=1, instr, long, pc=PC, next_pc=seq.
  - Flush beats stall.
- Interrupt FSM:
  - IDLE: irq_i=1 → PENDING on the next edge.
  - PENDING: entry occurs on the first edge with no ret/branch/jump and !stall_i. At entry:
    - epc_o ← PC (next unissued instruction, not yet in IF/ID);
    - PC ← INT_VECTOR;
    - irq_ack_o=1 for exactly one cycle;
    - → WAIT_RELEASE.
  - Entry never coincides with a redirect. A redirect while PENDING keeps it PENDING; EPC then captures the redirected PC at the later entry.
  - WAIT_RELEASE: → IDLE when irq_i=0. One entry per irq_i assertion; a level held high does not retrigger.
  - epc_o holds its value until the next entry.
- Latency:
  - An instruction at PC appears on ifid_* one edge after PC is presented.
  - Redirect penalty: one bubble, target instruction appears two edges after the redirect.

Test Plan:
- Reset release: RESET_VECTOR=32, mem[32]=0x1234 (bit15=0), mem[33]=0x8001 (long), mem[34]=0xABCD → IF/ID shows pc=32 instr=0x12340000 long=0; then pc=33 instr=0x8001ABCD long=1 next_pc=35; PC=35.
- Stall: assert stall_i for 3 cycles at PC=40 → PC stays 40, IF/ID outputs constant; flush_i with stall_i → valid=0 next edge.
- Simultaneous redirects: ret_i (target 0x100), branch_i (0x200), jump_i (0x300) in one cycle → PC=0x100, IF/ID bubble; branch+jump only → PC=0x200.
- Interrupt: irq_i=1 at PC=50, no stall → PENDING, next edge irq_ack_o=1 for one cycle, epc_o=PC at entry, PC=INT_VECTOR=0, bubble; irq_i held 10 cycles → no second ack; drop and reassert → second ack.
- Interrupt deferred by stall and branch: PENDING with stall_i=1 for 2 cycles, then branch_i to 0x80 → no ack; next free cycle ack with epc_o=0x80.
- Wrap/reset: PC=0xFFFFFFFF, short instruction → next PC=0; long → 1; async reset asserted mid-cycle → outputs zero immediately, PC=RESET_VECTOR.
